// File: rtl/io_handshake_unit_if.sv
// io_handshake_unit_if
//   Bundle of decoder, board and CPU-facing signals serviced by the
//   I/O handshake responder.
//   master : CPU/board side. Drives the instruction flags, the register value,
//            the switches and the raw button. Observes stall and the results.
//   slave  : io_handshake_unit. Observes the flags and board inputs. Drives
//            stall, the input write-back data/strobe, the display latch and
//            the status bits.
interface io_handshake_unit_if #(
  parameter int DATA_W = 32,
  parameter int SW_W   = 16
);
  logic              input_flag;
  logic              output_flag;
  logic              halt;
  logic [DATA_W-1:0] out_data;
  logic [SW_W-1:0]   switches;
  logic              confirm_btn;
  logic              stall;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] display_value;
  logic              display_valid;
  logic              waiting_input;
  logic              halted;

  modport master (
    output input_flag, output_flag, halt, out_data, switches, confirm_btn,
    input  stall, in_data, in_valid, display_value, display_valid,
           waiting_input, halted
  );

  modport slave (
    input  input_flag, output_flag, halt, out_data, switches, confirm_btn,
    output stall, in_data, in_valid, display_value, display_valid,
           waiting_input, halted
  );
endinterface

// File: rtl/io_handshake_unit.sv
// io_handshake_unit
//   Responder for the CPU I/O instructions (Input, Output, HALT).
//   Ports:
//     clk   : system clock, all state on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : io_handshake_unit_if.slave
//             in : input_flag, output_flag, halt, out_data, switches,
//                  confirm_btn (raw, asynchronous, active high)
//             out: stall (combinational), in_data, in_valid, display_value,
//                  display_valid, waiting_input, halted (all registered)
//   The button passes through a 2-flop synchronizer and a debouncer. An Input
//   stalls the pipeline until the debounced button is pressed. Then the
//   switches are captured and stall drops for one write-back cycle. The unit
//   then waits for release so one press never serves two Inputs.
module io_handshake_unit #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  io_handshake_unit_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_IN_WAIT    = 3'd1,
    ST_IN_DONE    = 3'd2,
    ST_IN_RELEASE = 3'd3,
    ST_HALTED     = 3'd4
  } state_t;

  logic              sync1_q, sync2_q;
  logic              btn_level_q, btn_level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] in_data_q;
  logic              in_valid_q;
  logic [DATA_W-1:0] display_value_q;
  logic              display_valid_q;
  logic              waiting_input_q;
  logic              halted_q;
  logic              stall_s;
  logic              capture_s;
  logic              disp_wr_s;
  logic              svc_output_s;

  // Output is serviced only when neither halt nor input_flag outranks it.
  assign svc_output_s = bus.output_flag & ~bus.halt & ~bus.input_flag;

  // Debouncer next state: the level flips on the DEBOUNCE_CYCLES-th
  // consecutive differing sample. Any matching sample restarts the count.
  always_comb begin
    btn_level_d = btn_level_q;
    cnt_d       = cnt_q;
    if (sync2_q != btn_level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_level_d = sync2_q;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Button synchronizer and debouncer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      btn_level_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= bus.confirm_btn;
      sync2_q     <= sync1_q;
      btn_level_q <= btn_level_d;
      cnt_q       <= cnt_d;
    end
  end

  // FSM next state and the combinational stall.
  always_comb begin
    state_d   = state_q;
    stall_s   = 1'b0;
    capture_s = 1'b0;
    disp_wr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A HALT also holds the PC on the cycle it is decoded.
        stall_s = bus.halt | bus.input_flag;
        if (bus.halt) begin
          state_d = ST_HALTED;
        end else if (bus.input_flag) begin
          state_d = ST_IN_WAIT;
        end else begin
          state_d   = ST_IDLE;
          disp_wr_s = svc_output_s;
        end
      end
      ST_IN_WAIT: begin
        // halt is deliberately not sampled: the Input instruction is held.
        stall_s = 1'b1;
        if (btn_level_q) begin
          capture_s = 1'b1;
          state_d   = ST_IN_DONE;
        end else begin
          state_d = ST_IN_WAIT;
        end
      end
      ST_IN_DONE: begin
        stall_s = 1'b0;
        state_d = ST_IN_RELEASE;
      end
      ST_IN_RELEASE: begin
        stall_s   = bus.halt | bus.input_flag;
        disp_wr_s = svc_output_s;
        if (bus.halt) begin
          state_d = ST_HALTED;
        end else if (!btn_level_q) begin
          state_d = bus.input_flag ? ST_IN_WAIT : ST_IDLE;
        end else begin
          state_d = ST_IN_RELEASE;
        end
      end
      ST_HALTED: begin
        stall_s = 1'b1;
        state_d = ST_HALTED;
      end
      default: begin
        stall_s = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      in_data_q       <= '0;
      in_valid_q      <= 1'b0;
      display_value_q <= '0;
      display_valid_q <= 1'b0;
      waiting_input_q <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_valid_q <= capture_s;
      if (capture_s) begin
        in_data_q <= DATA_W'(bus.switches);
      end
      if (disp_wr_s) begin
        display_value_q <= bus.out_data;
        display_valid_q <= 1'b1;
      end
      waiting_input_q <= (state_d == ST_IN_WAIT);
      halted_q        <= (state_d == ST_HALTED);
    end
  end

  assign bus.stall         = stall_s;
  assign bus.in_data       = in_data_q;
  assign bus.in_valid      = in_valid_q;
  assign bus.display_value = display_value_q;
  assign bus.display_valid = display_valid_q;
  assign bus.waiting_input = waiting_input_q;
  assign bus.halted        = halted_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// tb_io_handshake_unit
//   Directed bench for io_handshake_unit. Inputs change just after each
//   falling edge. Outputs are sampled 1 time unit later, so registered outputs
//   show the last rising edge and stall shows the current inputs.
module tb_io_handshake_unit;

  localparam int DATA_W    = 32;
  localparam int SW_W      = 16;
  localparam int DB        = 4;
  // Sync (2) + debounce (DB) + the FSM edge that registers the result.
  localparam int PRESS_LAT = 2 + DB + 1;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   pulses;
  logic [SW_W-1:0] sw_v;

  io_handshake_unit_if #(.DATA_W(DATA_W), .SW_W(SW_W)) bus ();

  io_handshake_unit #(.DATA_W(DATA_W), .SW_W(SW_W), .DEBOUNCE_CYCLES(DB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        inf;
    logic        outf;
    logic        hlt;
    logic [31:0] od;
    logic        e_stall;
    logic [31:0] e_disp;
    logic        e_dv;
    logic        e_wait;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic inf, input logic outf, input logic hlt,
                       input logic [31:0] od, input logic btn);
    @(negedge clk);
    bus.input_flag  = inf;
    bus.output_flag = outf;
    bus.halt        = hlt;
    bus.out_data    = od;
    bus.switches    = sw_v;
    bus.confirm_btn = btn;
    #1;
    if (bus.in_valid === 1'b1) pulses++;
  endtask

  // Drop rst_n between clock edges and expect every output to clear at once.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    bus.input_flag  = 1'b0;
    bus.output_flag = 1'b0;
    bus.halt        = 1'b0;
    bus.confirm_btn = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, " stall"},         32'(bus.stall),         32'd0);
    chk({tag, " in_data"},       bus.in_data,            32'd0);
    chk({tag, " in_valid"},      32'(bus.in_valid),      32'd0);
    chk({tag, " display_value"}, bus.display_value,      32'd0);
    chk({tag, " display_valid"}, 32'(bus.display_valid), 32'd0);
    chk({tag, " waiting_input"}, 32'(bus.waiting_input), 32'd0);
    chk({tag, " halted"},        32'(bus.halted),        32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  found;
    errors = 0;
    checks = 0;
    pulses = 0;
    sw_v   = 16'h00A5;
    rst_n  = 1'b1;
    bus.input_flag  = 1'b0;
    bus.output_flag = 1'b0;
    bus.halt        = 1'b0;
    bus.out_data    = 32'd0;
    bus.switches    = sw_v;
    bus.confirm_btn = 1'b0;

    mid_reset("reset0");

    // inf outf hlt od | stall disp dv wait
    tbl[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h1111_1111, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 32'h1111_1111, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h2222_2222, 1'b1, 1'b0};
    // Input outranks Output: display must not take 3333_3333.
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h3333_3333, 1'b1, 32'h2222_2222, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h2222_2222, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].inf, tbl[i].outf, tbl[i].hlt, tbl[i].od, 1'b0);
      chk($sformatf("vec%0d stall", i),         32'(bus.stall),         32'(tbl[i].e_stall));
      chk($sformatf("vec%0d display_value", i), bus.display_value,      tbl[i].e_disp);
      chk($sformatf("vec%0d display_valid", i), 32'(bus.display_valid), 32'(tbl[i].e_dv));
      chk($sformatf("vec%0d waiting_input", i), 32'(bus.waiting_input), 32'(tbl[i].e_wait));
      chk($sformatf("vec%0d in_valid", i),      32'(bus.in_valid),      32'd0);
    end

    // Glitch: 3 high samples in IN_WAIT must be rejected.
    pulses = 0;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, (i < 3) ? 1'b1 : 1'b0);
      chk($sformatf("glitch stall c%0d", i), 32'(bus.stall), 32'd1);
    end
    chk("glitch pulses", 32'(pulses), 32'd0);
    chk("glitch waiting_input", 32'(bus.waiting_input), 32'd1);

    // Clean press: write-back strobe PRESS_LAT cycles after the press.
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i <= 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      if (bus.in_valid === 1'b1) begin
        found = 1'b1;
        lat   = i;
        break;
      end
      chk($sformatf("press stall c%0d", i), 32'(bus.stall), 32'd1);
    end
    chk("press seen", 32'(found), 32'd1);
    chk("press latency", 32'(lat), 32'(PRESS_LAT));
    chk("press in_data", bus.in_data, 32'h0000_00A5);
    chk("press done stall", 32'(bus.stall), 32'd0);
    chk("press done waiting_input", 32'(bus.waiting_input), 32'd0);

    // Second Input with the button still held: stalls, no strobe.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      chk($sformatf("held stall c%0d", i), 32'(bus.stall), 32'd1);
    end
    chk("held waiting_input", 32'(bus.waiting_input), 32'd0);
    found = 1'b0;
    lat   = 0;
    for (int i = 0; i <= 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      if (bus.waiting_input === 1'b1) begin
        found = 1'b1;
        lat   = i;
        break;
      end
    end
    chk("release seen", 32'(found), 32'd1);
    chk("release latency", 32'(lat), 32'(PRESS_LAT));
    sw_v = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      chk($sformatf("rewait stall c%0d", i), 32'(bus.stall), 32'd1);
    end
    found = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      if (bus.in_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("second press seen", 32'(found), 32'd1);
    chk("second in_data", bus.in_data, 32'h0000_BEEF);
    chk("two inputs pulses", 32'(pulses), 32'd2);

    // IN_RELEASE: no stall without input_flag; Output still serviced.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("release stall", 32'(bus.stall), 32'd0);
    chk("release in_valid", 32'(bus.in_valid), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 32'h0BAD_F00D, 1'b0);
    chk("release out stall", 32'(bus.stall), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("release out display", bus.display_value, 32'h0BAD_F00D);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // halt together with output_flag: halt wins, display untouched.
    drive(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("halt halted", 32'(bus.halted), 32'd1);
    chk("halt stall", 32'(bus.stall), 32'd1);
    chk("halt display", bus.display_value, 32'h0BAD_F00D);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, (i < 8) ? 1'b1 : 1'b0);
      chk($sformatf("halted stall c%0d", i), 32'(bus.stall), 32'd1);
      chk($sformatf("halted flag c%0d", i), 32'(bus.halted), 32'd1);
    end
    chk("halted display", bus.display_value, 32'h0BAD_F00D);
    chk("halted waiting_input", 32'(bus.waiting_input), 32'd0);
    chk("halted pulses", 32'(pulses), 32'd2);

    // Only reset leaves HALTED; then Output works again.
    mid_reset("reset1");
    drive(1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
    chk("post reset stall", 32'(bus.stall), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("post reset halted", 32'(bus.halted), 32'd0);
    chk("post reset display", bus.display_value, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_handshake_unit.md
Name: io_handshake_unit

Overview:
- Responder side of the CPU I/O instructions: consumes input_flag/output_flag/halt issued by the opcode decoder and services them against board switches, a confirm button and a display register.
- Input: freezes the pipeline until the operator confirms with the button, then returns the switch value for register write-back.
- Output: latches the register value for the display in one cycle.
- Halt: parks the unit in a terminal state until reset.

Parameters:
- DATA_W, 32, width of CPU data path (in_data, out_data, display_value)
- SW_W, 16, number of board switches; must be <= DATA_W
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change; must be >= 1

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- input_flag  input  1  decoder: current instruction is Input
- output_flag  input  1  decoder: current instruction is Output
- halt  input  1  decoder: current instruction is HALT
- out_data  input  DATA_W  register value to display (Output instruction)
- switches  input  SW_W  board switches, quasi-static
- confirm_btn  input  1  raw asynchronous push button, active high
- stall  output  1  combinational; holds PC/pipeline while 1
- in_data  output  DATA_W  registered; zero-extended switches captured at confirm
- in_valid  output  1  registered; 1-cycle write-back strobe for Input
- display_value  output  DATA_W  registered display latch
- display_valid  output  1  registered; sticky, set by first Output
- waiting_input  output  1  registered; 1 while waiting for the operator
- halted  output  1  registered; 1 in HALTED

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_data=0, in_valid=0, display_value=0, display_valid=0, waiting_input=0, halted=0, synchronizer flops=0, debounced level=0, debounce counter=0. Reset mid-wait aborts the operation; no in_valid is produced.
- Button path: 2-flop synchronizer, then a debouncer. The counter increments while the synchronized value differs from the debounced level and clears when they match. When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears. A press is seen at the FSM 2+DEBOUNCE_CYCLES cycles after a clean edge. Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Priority when several flags are set in the same cycle: halt > input_flag > output_flag. The lower-priority flags are ignored that cycle.
- FSM states: IDLE, IN_WAIT, IN_DONE, IN_RELEASE, HALTED.
- IDLE:
  - halt -> HALTED.
  - input_flag: stall=1 combinationally, next state IN_WAIT.
  - output_flag: display_value<=out_data and display_valid<=1 on the same edge; stall=0; stay in IDLE.
- IN_WAIT:
  - stall=1, waiting_input=1.
  - When the debounced level is 1: in_data<={zeros, switches}, in_valid<=1, next state IN_DONE.
  - halt is not sampled here; the instruction is held.
- IN_DONE:
  - stall=0 for exactly this cycle, so the CPU writes in_data and advances PC.
  - in_valid=1 for this cycle only. Next state IN_RELEASE.
- IN_RELEASE:
  - Waits for the debounced level to return to 0.
  - stall=0 unless input_flag=1. In that case stall=1 and the unit waits for release, then goes to IN_WAIT; one press never satisfies two Inputs.
  - output_flag is serviced here exactly as in IDLE.
  - halt -> HALTED.
  - When released with no input_flag -> IDLE.
- HALTED:
  - halted=1, stall=1. All flags and the button are ignored.
  - Exit only via rst_n.
- waiting_input is registered: high on the cycle after entering IN_WAIT, low on the cycle after leaving it.
- Consecutive Outputs on back-to-back cycles each update display_value; last write wins.

Test Plan:
- Reset with rst_n=0 mid-cycle -> all outputs 0 immediately, with no clock edge required.
- output_flag=1 for 1 cycle, out_data=32'hDEADBEEF -> display_value=32'hDEADBEEF and display_valid=1 after the edge; stall=0 throughout.
- input_flag held, switches=16'h00A5, clean press after 10 cycles -> stall=1 until press+2+4 cycles, then one cycle with in_valid=1, in_data=32'h000000A5, stall=0.
- Glitch: button high for 3 cycles (DEBOUNCE_CYCLES=4) during IN_WAIT -> no in_valid, stall stays 1.
- Two back-to-back Inputs with the button held down -> second Input stalls until release plus debounce, then needs a new press; exactly two in_valid pulses total.
- halt=1 together with output_flag=1 in IDLE -> halted=1 and stall=1; display_value unchanged. Later flags are ignored until rst_n pulses.
